// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive path.
//   - rx_state_t : receiver FSM states
//   - OVERSAMPLE : tick_16x strobes per bit
//   - MID_SAMPLE : tick count at which the start bit is re-checked
//   - LAST_TICK  : tick count at which data/parity/stop bits are sampled
//   - frame_parity() : even/odd parity of a received word
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

  // Expected parity bit for a word (zero-extended to 9 bits, so unused upper
  // bits do not affect the result). odd=0 gives even parity.
  function automatic logic frame_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial line plus a falling-edge
//   detector on the synchronised signal.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high
//     rx     in   asynchronous serial line (idle high)
//     rx_s   out  synchronised line
//     fall   out  1 for one cycle on a high->low transition of rx_s
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic       rx_meta_reg;
  logic       rx_s_reg;
  logic       rx_prev_reg;
  logic [1:0] prime_reg;

  // Both synchroniser flops reset high (idle line). Their reset value is not
  // a real observation of the line, so the edge detector's history flop is
  // held at 0 until the pipeline has been refilled from rx (prime_reg == 2).
  // A line that is already low when reset is released therefore cannot look
  // like a start edge; it must be seen high first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b0;
      prime_reg   <= 2'd0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      if (prime_reg != 2'd2) begin
        prime_reg <= prime_reg + 2'd1;
      end
      rx_prev_reg <= (prime_reg == 2'd2) & rx_s_reg;
    end
  end

  assign rx_s = rx_s_reg;
  assign fall = rx_prev_reg & ~rx_s_reg;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver: synchronises rx, detects start bits, samples each bit at
//   its mid-point using the 16x tick from the baud generator, deserialises
//   LSB-first and presents words on a valid/ready interface.
//   Optional feature macro: UART_RX_PARITY_EN (adds one parity bit per frame).
//   Parameters:
//     DATA_BITS   data bits per frame (5..9)
//     PARITY_ODD  parity sense when parity is enabled: 0 even, 1 odd
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous, active-high
//     tick_16x     in   one-cycle strobe at 16x baud
//     rx           in   asynchronous serial line, idle high
//     rx_data      out  received word, stable while rx_valid=1
//     rx_valid     out  word available, held until accepted
//     rx_ready     in   consumer accepts when rx_valid & rx_ready
//     frame_err    out  pulse: stop bit sampled low
//     parity_err   out  pulse: parity mismatch (always 0 without parity)
//     overrun_err  out  pulse: frame completed while previous word unaccepted
//     busy         out  1 while receiving a frame
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int               IDX_W    = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_t            state_reg,   state_next;
  logic [3:0]           cnt_reg,     cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic                 stop_sample;

  logic [DATA_BITS-1:0] rx_data_reg,     rx_data_next;
  logic                 rx_valid_reg,    rx_valid_next;
  logic                 frame_err_reg,   frame_err_next;
  logic                 parity_err_reg,  parity_err_next;
  logic                 overrun_err_reg, overrun_err_next;
  logic                 load;

`ifdef UART_RX_PARITY_EN
  logic par_bit_reg, par_bit_next;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= par_bit_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state. The tick counter only moves on tick_16x and is
  // cleared explicitly at each sample point, so it never wraps by itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    stop_sample  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = 4'd0;
        end
      end

      START: begin
        if (tick_16x) begin
          if (cnt_reg == MID_SAMPLE) begin
            cnt_next = 4'd0;
            if (!rx_s) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              // Line back high at mid start bit: glitch, not a frame.
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick_16x) begin
          if (cnt_reg == LAST_TICK) begin
            cnt_next     = 4'd0;
            // Shifting in from the top leaves the first (LSB) bit at bit 0
            // once all DATA_BITS samples have been taken.
            shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + 1'b1;
            if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick_16x) begin
          if (cnt_reg == LAST_TICK) begin
            cnt_next     = 4'd0;
            par_bit_next = rx_s;
            state_next   = STOP;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
`else
        state_next = IDLE;
`endif
      end

      STOP: begin
        if (tick_16x) begin
          if (cnt_reg == LAST_TICK) begin
            cnt_next    = 4'd0;
            stop_sample = 1'b1;
            state_next  = IDLE;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output side. A completed frame is loaded if the holding register is empty
  // or is being emptied in this same cycle; otherwise the new word is dropped.
  // Results appear one clock after the stop-bit sample.
  // ---------------------------------------------------------------------------
  always_comb begin
    load             = stop_sample & (~rx_valid_reg | rx_ready);
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    frame_err_next   = load & ~rx_s;
    overrun_err_next = stop_sample & rx_valid_reg & ~rx_ready;
`ifdef UART_RX_PARITY_EN
    parity_err_next  = load & (par_bit_reg != frame_parity(9'(shift_reg), PARITY_ODD));
`else
    // No parity bit on the wire, so the parity sense cannot matter.
    parity_err_next  = 1'b0 & PARITY_ODD;
`endif

    if (load) begin
      rx_data_next  = shift_reg;
      rx_valid_next = 1'b1;
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      parity_err_reg  <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      frame_err_reg   <= frame_err_next;
      parity_err_reg  <= parity_err_next;
      overrun_err_reg <= overrun_err_next;
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_err   = frame_err_reg;
  assign parity_err  = parity_err_reg;
  assign overrun_err = overrun_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. A local tick generator stands in for the
//   baud generator (one tick_16x every TICK_DIV clocks) so frames stay short.
//   Serial frames are driven bit by bit, 16 ticks per bit; a monitor counts
//   handshakes and status pulses, and each frame is judged against expected
//   values from a table or from a simple arithmetic model of the frame rules.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam bit PARITY_ODD = 1'b0;
  localparam int TICK_DIV   = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick_16x = 1'b0;
  logic                 rx = 1'b1;
  logic                 rx_ready = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  uart_rx #(
    .DATA_BITS  (DATA_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_16x    (tick_16x),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clock high every TICK_DIV clocks.
  int tick_cnt = 0;
  always @(posedge clk) begin
    if (tick_cnt == TICK_DIV - 1) begin
      tick_cnt <= 0;
      tick_16x <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      tick_16x <= 1'b0;
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  int         n_acc = 0;
  int         n_valid_cyc = 0;
  int         n_busy_cyc = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_oerr = 0;
  logic [7:0] acc_data [0:255];

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready && n_acc < 256) begin
        acc_data[n_acc] = rx_data;
        n_acc = n_acc + 1;
      end
      if (rx_valid)    n_valid_cyc = n_valid_cyc + 1;
      if (busy)        n_busy_cyc  = n_busy_cyc + 1;
      if (frame_err)   n_ferr      = n_ferr + 1;
      if (parity_err)  n_perr      = n_perr + 1;
      if (overrun_err) n_oerr      = n_oerr + 1;
    end
  end

  // Run-time guard: the stimulus has no open-ended waits, but never hang.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference rule for the parity bit: count of ones plus the odd/even sense.
  function automatic logic good_par(input logic [7:0] d);
    return 1'(($countones(d) + int'(PARITY_ODD)) % 2);
  endfunction

  task automatic hold(input logic v, input int ticks);
    rx = v;
    repeat (ticks * TICK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold(1'b0, 16);
    for (int i = 0; i < DATA_BITS; i++) hold(d[i], 16);
    if (PAR_EN) hold(par, 16);
    hold(stop, 16);
    hold(1'b1, 4);
  endtask

  // Sends one frame with rx_ready=1 and compares everything it produced.
  task automatic run_frame(input logic [7:0] d, input logic par, input logic stop,
                           input logic exp_ferr, input logic exp_perr);
    int a0 = n_acc;
    int v0 = n_valid_cyc;
    int f0 = n_ferr;
    int p0 = n_perr;
    int o0 = n_oerr;
    send_frame(d, par, stop);
    $display("frame data=%02h par=%0d stop=%0d -> words=%0d data=%02h ferr=%0d perr=%0d oerr=%0d",
             d, par, stop, n_acc - a0, acc_data[a0], n_ferr - f0, n_perr - p0, n_oerr - o0);
    chk("words", n_acc - a0, 1);
    chk("rx_data", int'(acc_data[a0]), int'(d));
    chk("valid_cycles", n_valid_cyc - v0, 1);
    chk("frame_err", n_ferr - f0, int'(exp_ferr));
    chk("parity_err", n_perr - p0, int'(exp_perr));
    chk("overrun_err", n_oerr - o0, 0);
    chk("busy_after", int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int a0;
    int b0;
    int f0;
    int p0;
    int o0;
    logic [7:0] d;
    logic       stop;
    logic       par;

    vecs[0] = '{8'hA5, good_par(8'hA5), 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, good_par(8'h3C), 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, good_par(8'h00), 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, good_par(8'hFF), 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, good_par(8'h01), 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, good_par(8'h80), 1'b1, 1'b0, 1'b0};

    // Reset state.
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_overrun_err", int'(overrun_err), 0);
    hold(1'b1, 4);

    // Table-driven frames, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].exp_ferr, vecs[i].exp_perr);
    end

    // Short low glitch: line is back high by the start-bit mid-sample.
    a0 = n_acc; b0 = n_busy_cyc; f0 = n_ferr; o0 = n_oerr;
    hold(1'b0, 3);
    chk("glitch_busy_high", int'(busy), 1);
    hold(1'b0, 2);
    hold(1'b1, 20);
    $display("glitch -> words=%0d busy=%0d busy_cycles=%0d", n_acc - a0, busy, n_busy_cyc - b0);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_words", n_acc - a0, 0);
    chk("glitch_valid", int'(rx_valid), 0);
    chk("glitch_errs", (n_ferr - f0) + (n_oerr - o0), 0);

    // Overrun: two frames with the consumer stalled.
    rx_ready = 1'b0;
    a0 = n_acc; f0 = n_ferr; o0 = n_oerr;
    send_frame(8'h11, good_par(8'h11), 1'b1);
    $display("stalled frame 11 -> valid=%0d data=%02h", rx_valid, rx_data);
    chk("stall1_valid", int'(rx_valid), 1);
    chk("stall1_data", int'(rx_data), 'h11);
    chk("stall1_overrun", n_oerr - o0, 0);
    send_frame(8'h22, good_par(8'h22), 1'b1);
    $display("stalled frame 22 -> valid=%0d data=%02h overruns=%0d", rx_valid, rx_data, n_oerr - o0);
    chk("stall2_valid", int'(rx_valid), 1);
    chk("stall2_data", int'(rx_data), 'h11);
    chk("stall2_overrun", n_oerr - o0, 1);
    chk("stall2_frame_err", n_ferr - f0, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("release ready -> valid=%0d accepted=%0d data=%02h", rx_valid, n_acc - a0, acc_data[a0]);
    chk("release_valid", int'(rx_valid), 0);
    chk("release_words", n_acc - a0, 1);
    chk("release_data", int'(acc_data[a0]), 'h11);

    // Reset during data bit 3 of 0xFF, released while the line is low.
    hold(1'b0, 16);
    hold(1'b1, 48);
    hold(1'b1, 8);
    chk("midframe_busy", int'(busy), 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_rx_valid", int'(rx_valid), 0);
    chk("rst2_rx_data", int'(rx_data), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_pulses", int'(frame_err) + int'(parity_err) + int'(overrun_err), 0);
    a0 = n_acc; b0 = n_busy_cyc;
    hold(1'b0, 40);
    $display("low after reset -> words=%0d busy_cycles=%0d", n_acc - a0, n_busy_cyc - b0);
    chk("low_busy_cycles", n_busy_cyc - b0, 0);
    chk("low_words", n_acc - a0, 0);
    hold(1'b1, 16);
    run_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0, 1'b0);

    // Random frames against the reference rules.
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = 1'($urandom_range(0, 1));
      run_frame(d, par, stop, !stop, PAR_EN && (par != good_par(d)));
    end

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07: correct parity bit is 1.
    p0 = n_perr;
    run_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par07_ok", n_perr - p0, 0);
    p0 = n_perr;
    run_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("par07_bad", n_perr - p0, 1);
`else
    p0 = n_perr;
    chk("parity_tied", n_perr - p0 + int'(parity_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
